// File: rtl/hist_bin_accum_if.sv
// hist_bin_accum_if
//   Bundles the increment, host-read and status signals of the histogram
//   accumulator so producer and consumer connect through a single port.
//
//   Signals (direction seen from the master, i.e. the driver side):
//     ram_en    out  increment strobe, one increment per cycle high
//     addr_r    out  bin to increment, qualified by ram_en
//     use_JTAG  out  1: host read mode (increments dropped), 0: increment mode
//     rd_req    out  host read request, qualified by use_JTAG
//     rd_addr   out  bin to read
//     rd_valid  in   one-cycle pulse, rd_data valid
//     rd_data   in   bin count
//     busy      in   clear sweep in progress
//     ovf       in   sticky: some bin saturated/wrapped
//     drop_cnt  in   saturating count of dropped ram_en strobes
//
//   Modports: master (event source / host side), slave (hist_bin_accum).
`timescale 1ns/1ps

interface hist_bin_accum_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              ram_en;
    logic [ADDR_W-1:0] addr_r;
    logic              use_JTAG;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic              busy;
    logic              ovf;
    logic [15:0]       drop_cnt;

    modport master (
        output ram_en, addr_r, use_JTAG, rd_req, rd_addr,
        input  rd_valid, rd_data, busy, ovf, drop_cnt
    );

    modport slave (
        input  ram_en, addr_r, use_JTAG, rd_req, rd_addr,
        output rd_valid, rd_data, busy, ovf, drop_cnt
    );
endinterface

// File: rtl/hist_bin_accum.sv
// hist_bin_accum
//   Pipelined histogram RAM. Each accepted strobe increments one bin counter
//   through a 3-stage read-modify-write pipeline:
//     S0  accept, issue synchronous RAM read
//     S1  RAM data returns, forwarding picks the newest in-flight value
//     S2  add 1 (saturate or wrap), write back
//   Host reads share the same pipeline and return the count two cycles after
//   the request. After reset a sweep clears every bin, one per cycle.
//
//   Ports:
//     clk   in  clock
//     rst   in  asynchronous active-high reset
//     bus   hist_bin_accum_if.slave (increment, host read and status signals)
//
//   Parameters: ADDR_W (bin index width), CNT_W (counter width),
//               SAT (1: saturate at max, 0: wrap to 0).
//
//   Build option: HIST_CLR_ON_READ_EN -- when defined, each accepted host
//   read also writes 0 to the bin in S2 (the old value is still returned).
`timescale 1ns/1ps

module hist_bin_accum #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16,
    parameter bit SAT    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    hist_bin_accum_if.slave bus
);
    localparam int               DEPTH   = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef HIST_CLR_ON_READ_EN
    localparam bit CLR_ON_READ = 1'b1;
`else
    localparam bit CLR_ON_READ = 1'b0;
`endif

    typedef enum logic {
        ST_SWEEP,
        ST_RUN
    } state_e;

    typedef enum logic {
        OP_INC,
        OP_RD
    } op_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] ram_q;

    state_e            state;
    logic              busy_q;
    logic [ADDR_W-1:0] sweep_ptr;

    // S1: read data is returning from the RAM
    logic              s1_valid;
    op_e               s1_op;
    logic [ADDR_W-1:0] s1_addr;
    logic [CNT_W-1:0]  s1_base;

    // S2: modify and write back
    logic              s2_valid;
    op_e               s2_op;
    logic [ADDR_W-1:0] s2_addr;
    logic [CNT_W-1:0]  s2_base;
    logic              s2_wr;
    logic [CNT_W-1:0]  s2_wdata;
    logic              s2_at_max;

    // Copy of the write performed at the previous edge. The RAM read for the
    // op now in S1 happened on that same edge and returned the pre-write data.
    logic              s3_valid;
    logic [ADDR_W-1:0] s3_addr;
    logic [CNT_W-1:0]  s3_data;

    logic              rd_valid_q;
    logic [CNT_W-1:0]  rd_data_q;
    logic              ovf_q;
    logic [15:0]       drop_q;

    // ------------------------------------------------------------------
    // S0: accept. use_JTAG makes increments and reads mutually exclusive.
    // ------------------------------------------------------------------
    logic              inc_acc;
    logic              rd_acc;
    logic              s0_valid;
    op_e               s0_op;
    logic [ADDR_W-1:0] s0_addr;

    assign inc_acc  = bus.ram_en & ~busy_q & ~bus.use_JTAG;
    assign rd_acc   = bus.rd_req & bus.use_JTAG & ~busy_q;
    assign s0_valid = inc_acc | rd_acc;
    assign s0_op    = rd_acc ? OP_RD : OP_INC;
    assign s0_addr  = bus.use_JTAG ? bus.rd_addr : bus.addr_r;

    // ------------------------------------------------------------------
    // S1 forwarding: the S2 result is newer than the previous write, which
    // in turn is newer than the RAM output.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns s1_base; no latch.
        s1_base = ram_q;
        if (s3_valid && (s3_addr == s1_addr)) begin
            s1_base = s3_data;
        end
        if (s2_wr && (s2_addr == s1_addr)) begin
            s1_base = s2_wdata;
        end
    end

    // ------------------------------------------------------------------
    // S2 arithmetic. Reads write back only in clear-on-read builds.
    // ------------------------------------------------------------------
    assign s2_at_max = (s2_base == CNT_MAX);
    assign s2_wr     = s2_valid & ((s2_op == OP_INC) | CLR_ON_READ);

    always_comb begin
        s2_wdata = '0;
        if (s2_op == OP_INC) begin
            if (s2_at_max) begin
                s2_wdata = SAT ? CNT_MAX : '0;
            end else begin
                s2_wdata = s2_base + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM: one write port (sweep or S2), one synchronous read port.
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; its contents are cleared by the sweep
    // after rst, which keeps it mappable onto a block RAM.
    always_ff @(posedge clk) begin
        if (busy_q) begin
            mem[sweep_ptr] <= '0;
        end else if (s2_wr) begin
            mem[s2_addr] <= s2_wdata;
        end
        ram_q <= mem[s0_addr];
    end

    // ------------------------------------------------------------------
    // Control, pipeline registers and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SWEEP;
            busy_q     <= 1'b1;
            sweep_ptr  <= '0;
            s1_valid   <= 1'b0;
            s1_op      <= OP_INC;
            s1_addr    <= '0;
            s2_valid   <= 1'b0;
            s2_op      <= OP_INC;
            s2_addr    <= '0;
            s2_base    <= '0;
            s3_valid   <= 1'b0;
            s3_addr    <= '0;
            s3_data    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            case (state)
                ST_SWEEP: begin
                    sweep_ptr <= sweep_ptr + 1'b1;
                    if (sweep_ptr == ADDR_W'(DEPTH - 1)) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    busy_q <= 1'b0;
                end
            endcase

            s1_valid <= s0_valid;
            s1_op    <= s0_op;
            s1_addr  <= s0_addr;

            s2_valid <= s1_valid;
            s2_op    <= s1_op;
            s2_addr  <= s1_addr;
            s2_base  <= s1_base;

            s3_valid <= s2_wr;
            s3_addr  <= s2_addr;
            s3_data  <= s2_wdata;

            // Read result leaves with the op entering S2: request at n, pulse at n+2.
            rd_valid_q <= s1_valid & (s1_op == OP_RD);
            if (s1_valid && (s1_op == OP_RD)) begin
                rd_data_q <= s1_base;
            end

            if (s2_valid && (s2_op == OP_INC) && s2_at_max) begin
                ovf_q <= 1'b1;
            end

            if (bus.ram_en && !inc_acc && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = busy_q;
    assign bus.ovf      = ovf_q;
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_hist_bin_accum.sv
// tb_hist_bin_accum
//   Self-checking bench for hist_bin_accum. Three instances share stimulus:
//   dut_m (CNT_W=16, SAT=1), dut_s (CNT_W=4, SAT=1), dut_w (CNT_W=4, SAT=0).
//   A per-bin hit-count model supplies expected read values, which are queued
//   when a read is issued and compared when rd_valid pulses.
`timescale 1ns/1ps

module tb_hist_bin_accum;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

`ifdef HIST_CLR_ON_READ_EN
    localparam bit CLR_ON_READ = 1'b1;
`else
    localparam bit CLR_ON_READ = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    hist_bin_accum_if #(.ADDR_W(ADDR_W), .CNT_W(16)) if_m ();
    hist_bin_accum_if #(.ADDR_W(ADDR_W), .CNT_W(4))  if_s ();
    hist_bin_accum_if #(.ADDR_W(ADDR_W), .CNT_W(4))  if_w ();

    hist_bin_accum #(.ADDR_W(ADDR_W), .CNT_W(16), .SAT(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(if_m));
    hist_bin_accum #(.ADDR_W(ADDR_W), .CNT_W(4),  .SAT(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
    hist_bin_accum #(.ADDR_W(ADDR_W), .CNT_W(4),  .SAT(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(if_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int bin;
        int exp_m;
        int exp_s;
        int exp_w;
        int cyc;
    } sb_t;

    sb_t sb_q[$];
    int  hits[DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int val_sat4(int h);
        return (h > 15) ? 15 : h;
    endfunction

    function automatic int val_wrap4(int h);
        return h % 16;
    endfunction

    function automatic int val_m(int h);
        return (h > 65535) ? 65535 : h;
    endfunction

    task automatic drive(input logic en, input int a, input logic jtag, input logic req, input int ra);
        if_m.ram_en = en; if_m.addr_r = a[ADDR_W-1:0]; if_m.use_JTAG = jtag;
        if_m.rd_req = req; if_m.rd_addr = ra[ADDR_W-1:0];
        if_s.ram_en = en; if_s.addr_r = a[ADDR_W-1:0]; if_s.use_JTAG = jtag;
        if_s.rd_req = req; if_s.rd_addr = ra[ADDR_W-1:0];
        if_w.ram_en = en; if_w.addr_r = a[ADDR_W-1:0]; if_w.use_JTAG = jtag;
        if_w.rd_req = req; if_w.rd_addr = ra[ADDR_W-1:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inc(input int a);
        drive(1'b1, a, 1'b0, 1'b0, 0);
        hits[a]++;
        step();
    endtask

    task automatic rd(input int a);
        sb_t e;
        e.bin   = a;
        e.exp_m = val_m(hits[a]);
        e.exp_s = val_sat4(hits[a]);
        e.exp_w = val_wrap4(hits[a]);
        e.cyc   = cyc;
        sb_q.push_back(e);
        if (CLR_ON_READ) hits[a] = 0;
        drive(1'b0, 0, 1'b1, 1'b1, a);
        step();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, 1'b0, 1'b0, 0);
        repeat (n) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},     if_m.busy,     1);
        check({tag, "_rd_valid"}, if_m.rd_valid, 0);
        check({tag, "_rd_data"},  if_m.rd_data,  0);
        check({tag, "_ovf_m"},    if_m.ovf,      0);
        check({tag, "_ovf_s"},    if_s.ovf,      0);
        check({tag, "_drop"},     if_m.drop_cnt, 0);
    endtask

    // Scoreboard: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst && if_m.rd_valid) begin
            check("sb_has_entry", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                sb_t e;
                e = sb_q.pop_front();
                check($sformatf("rd_m_bin%0d", e.bin), if_m.rd_data, e.exp_m);
                check($sformatf("rd_valid_s_bin%0d", e.bin), if_s.rd_valid, 1);
                check($sformatf("rd_s_bin%0d", e.bin), if_s.rd_data, e.exp_s);
                check($sformatf("rd_valid_w_bin%0d", e.bin), if_w.rd_valid, 1);
                check($sformatf("rd_w_bin%0d", e.bin), if_w.rd_data, e.exp_w);
                check($sformatf("rd_latency_bin%0d", e.bin), cyc - e.cyc, 2);
            end
        end
    end

    initial begin
        int n;
        int list2[8] = '{1, 5, 6, 5, 5, 5, 5, 11};

        cyc = 0; n_checks = 0; n_errors = 0;
        foreach (hits[i]) hits[i] = 0;
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0, 0);
        repeat (3) step();
        check_reset_state("rst1");

        // Test 1: sweep length, then every bin reads 0.
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!if_m.busy) break;
            n++;
        end
        check("busy_cycles", n, 32);
        check("busy_s_low", if_s.busy, 0);
        step();
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(4);

        // Test 2: mixed run with back-to-back hits, read straight after the last one.
        for (int i = 0; i < 8; i++) inc(list2[i]);
        rd(11); rd(5); rd(6); rd(1);
        idle(4);
        check("ovf_m_t2", if_m.ovf, 0);
        check("ovf_s_t2", if_s.ovf, 0);
        check("ovf_w_t2", if_w.ovf, 0);

        // Test 4: 17 hits on bin 2 overflow the 4-bit counters.
        for (int i = 0; i < 17; i++) inc(2);
        rd(2);
        idle(4);
        check("ovf_m_t4", if_m.ovf, 0);
        check("ovf_s_t4", if_s.ovf, 1);
        check("ovf_w_t4", if_w.ovf, 1);

        // Test 3: 40 consecutive hits on bin 3.
        for (int i = 0; i < 40; i++) inc(3);
        rd(3);
        idle(4);

        // Test 6: back-to-back reads of bin 7 (second returns 0 when clear-on-read).
        for (int i = 0; i < 9; i++) inc(7);
        rd(7); rd(7);
        idle(4);
        rd(7);
        idle(4);
        check("sb_drained_1", sb_q.size(), 0);
        check("drop_before_t5", if_m.drop_cnt, 0);

        // Test 5: reset with increments in flight, then dropped strobes.
        inc(4); inc(4); inc(4);
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0, 0);
        step(); step();
        check_reset_state("rst2");
        foreach (hits[i]) hits[i] = 0;
        rst = 1'b0;
        drive(1'b1, 4, 1'b0, 1'b0, 0);
        repeat (10) step();
        drive(1'b0, 0, 1'b0, 1'b0, 0);
        n = 0;
        while (if_m.busy && n < 100) begin
            step();
            n++;
        end
        check("busy_fall_t5", if_m.busy, 0);
        drive(1'b1, 4, 1'b1, 1'b0, 0);
        repeat (4) step();
        idle(2);
        check("drop_m", if_m.drop_cnt, 14);
        check("drop_s", if_s.drop_cnt, 14);
        check("drop_w", if_w.drop_cnt, 14);
        rd(4); rd(0); rd(7);
        idle(4);
        check("sb_drained_2", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a wait above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks", n_checks);
        $fatal(1, "timeout");
    end

endmodule
